// File: rtl/event_delay_monitor.sv
// rtl/event_delay_monitor.sv - event1-to-event2 cycle delay monitor with window check and statistics
// Define EVENT_DELAY_TIMEOUT_EN to abort a measurement with max_error once it passes MAX_DELAY.
module event_delay_monitor #(
   parameter int CNT_WIDTH = 16,
   parameter int MIN_DELAY = 0,
   parameter int MAX_DELAY = 100
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 clear,
   input  logic                 event1,
   input  logic                 event2,
   output logic                 busy,
   output logic                 delay_valid,
   output logic [CNT_WIDTH-1:0] delay_count,
   output logic                 min_error,
   output logic                 max_error,
   output logic [7:0]           error_count,
   output logic [CNT_WIDTH-1:0] max_seen
);

   typedef enum logic {IDLE, ARMED} state_t;

   state_t               state, state_next;
   logic [CNT_WIDTH-1:0] counter, counter_next, delay_count_next, meas;
   logic                 event1_q, event2_q, rise1, rise2;
   logic                 valid_next, min_next, max_next;
   int                   meas_i;

   assign rise1  = event1 & ~event1_q;
   assign rise2  = event2 & ~event2_q;
   // delay if event2 rises at this edge; counter saturates rather than wraps
   assign meas   = (&counter) ? counter : counter + CNT_WIDTH'(1);
   assign meas_i = int'(meas);
   assign busy   = (state == ARMED);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         counter     <= '0;
         delay_count <= '0;
         delay_valid <= 1'b0;
         min_error   <= 1'b0;
         max_error   <= 1'b0;
         event1_q    <= 1'b0;
         event2_q    <= 1'b0;
      end else begin
         state       <= state_next;
         counter     <= counter_next;
         delay_count <= delay_count_next;
         delay_valid <= valid_next;
         min_error   <= min_next;
         max_error   <= max_next;
         event1_q    <= event1;
         event2_q    <= event2;
      end
   end

   always_comb begin
      state_next       = state;
      counter_next     = counter;
      delay_count_next = delay_count;
      valid_next       = 1'b0;
      min_next         = 1'b0;
      max_next         = 1'b0;
      if (!enable) begin
         state_next   = IDLE;
         counter_next = '0;
      end else begin
         case (state)
            IDLE: begin
               if (rise1) begin
                  state_next   = ARMED;
                  counter_next = '0;
               end
            end
            ARMED: begin
               if (rise2) begin
                  valid_next       = 1'b1;
                  delay_count_next = meas;
                  min_next         = (meas_i < MIN_DELAY);
                  max_next         = (meas_i > MAX_DELAY);
                  counter_next     = '0;
                  // a coincident event1 starts the next measurement immediately
                  if (!rise1)
                     state_next = IDLE;
               end else if (rise1) begin
                  counter_next = '0;
`ifdef EVENT_DELAY_TIMEOUT_EN
               end else if (int'(counter) == MAX_DELAY) begin
                  max_next     = 1'b1;
                  state_next   = IDLE;
                  counter_next = '0;
`endif
               end else begin
                  counter_next = meas;
               end
            end
            default: begin
               state_next   = IDLE;
               counter_next = '0;
            end
         endcase
      end
   end

   // statistics trail the registered pulses by one cycle; clear overrides that update
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         error_count <= 8'd0;
         max_seen    <= '0;
      end else if (clear) begin
         error_count <= 8'd0;
         max_seen    <= '0;
      end else begin
         if ((min_error || max_error) && error_count != 8'hFF)
            error_count <= error_count + 8'd1;
         if (delay_valid && delay_count > max_seen)
            max_seen <= delay_count;
      end
   end

endmodule
